// File: rtl/mem_port_arbiter_if.sv
// Core/memory bus bundle for mem_port_arbiter: fetch and data request channels plus the shared
// single memory port. The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch channel
  logic                  f_req;
  logic [ADDR_W-1:0]     f_addr;
  logic                  f_flush;
  logic                  f_gnt;
  logic                  f_rvalid;

  // Load/store channel
  logic                  d_req;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W/8-1:0]   d_we;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;

  // Shared response data
  logic [DATA_W-1:0]     rdata;

  // Memory port
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  f_req, f_addr, f_flush,
    output f_gnt, f_rvalid,
    input  d_req, d_addr, d_we, d_wdata,
    output d_gnt, d_rvalid,
    output rdata,
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy
  );

  modport master (
    output f_req, f_addr, f_flush,
    input  f_gnt, f_rvalid,
    output d_req, d_addr, d_we, d_wdata,
    input  d_gnt, d_rvalid,
    input  rdata,
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with a single outstanding transaction.
// Data has priority; fetch is forced through after MAX_STREAK data grants made while it waited.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned BE_W      = DATA_W / 8;
  localparam logic [3:0]  MaxStreak = 4'(MAX_STREAK);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q;
  logic              owner_q;   // 1: data owns the transaction, 0: fetch
  logic              kill_q;
  logic [3:0]        streak_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   we_q;
  logic [DATA_W-1:0] wdata_q;

  logic grant_d;
  logic grant_f;
  logic fetch_forced;

  // Arbitration only happens in IDLE; grants are combinational so the requester sees them at once.
  always_comb begin
    grant_d      = 1'b0;
    grant_f      = 1'b0;
    fetch_forced = bus.f_req && (streak_q == MaxStreak);
    if (state_q == StIdle) begin
      if (bus.d_req && !fetch_forced) begin
        grant_d = 1'b1;
      end else if (bus.f_req) begin
        grant_f = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      kill_q    <= 1'b0;
      streak_q  <= 4'd0;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
    end else begin
      // Streak only counts data wins that actually made fetch wait.
      if (!bus.f_req || grant_f) begin
        streak_q <= 4'd0;
      end else if (grant_d && (streak_q != MaxStreak)) begin
        streak_q <= streak_q + 4'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_d || grant_f) begin
            state_q   <= StReq;
            owner_q   <= grant_d;
            kill_q    <= 1'b0;
            mem_req_q <= 1'b1;
            addr_q    <= grant_d ? bus.d_addr : bus.f_addr;
            we_q      <= grant_d ? bus.d_we : '0;
            wdata_q   <= grant_d ? bus.d_wdata : '0;
          end
        end
        StReq: begin
          if (bus.f_flush && !owner_q) begin
            kill_q <= 1'b1;
          end
          if (bus.mem_gnt) begin
            state_q   <= StWait;
            mem_req_q <= 1'b0;
          end
        end
        StWait: begin
          if (bus.mem_rvalid) begin
            state_q <= StIdle;
            kill_q  <= 1'b0;
          end else if (bus.f_flush && !owner_q) begin
            kill_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
          kill_q    <= 1'b0;
        end
      endcase
    end
  end

  logic resp;
  assign resp = (state_q == StWait) && bus.mem_rvalid;

  assign bus.f_gnt     = grant_f;
  assign bus.d_gnt     = grant_d;
  // A flush arriving with the response itself still suppresses it.
  assign bus.f_rvalid  = resp && !owner_q && !kill_q && !bus.f_flush;
  assign bus.d_rvalid  = resp && owner_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all compared cycle by cycle
// against a transaction-level model of the arbiter's rules.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_STREAK(MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one outstanding transaction, accepted or not, plus data wins while fetch waited.
  bit          m_out, m_acc, m_own_d, m_kill;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_we;
  int          m_streak;

  // Outputs observed in the last completed cycle.
  logic        s_f_gnt, s_d_gnt, s_f_rv, s_d_rv, s_mem_req, s_busy;
  logic [31:0] s_addr, s_rdata;
  logic [3:0]  s_we;

  bit          log_en;
  int          g_count;
  logic [31:0] g_order;

  a_f_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.f_req && !bus.f_gnt) |=> bus.f_req);
  a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.d_req && !bus.d_gnt) |=> bus.d_req);
  a_gnt_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.f_gnt || bus.d_gnt) |-> !bus.busy);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_acc = 0; m_own_d = 0; m_kill = 0;
    m_addr = '0; m_wdata = '0; m_we = '0; m_streak = 0;
    s_f_gnt = 0; s_d_gnt = 0; s_f_rv = 0; s_d_rv = 0; s_mem_req = 0; s_busy = 0;
    s_addr = '0; s_rdata = '0; s_we = '0;
  endtask

  task automatic clear_inputs();
    bus.f_req = 0; bus.f_addr = '0; bus.f_flush = 0;
    bus.d_req = 0; bus.d_addr = '0; bus.d_we = '0; bus.d_wdata = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
  endtask

  // Called at a negedge with inputs set; checks just before the posedge and returns at the next negedge.
  task automatic cycle();
    bit ef, ed, efr, edr;
    #4;
    ef = 0;
    ed = 0;
    if (!m_out) begin
      if (bus.d_req && !(bus.f_req && m_streak == MAX)) ed = 1;
      else if (bus.f_req) ef = 1;
    end
    edr = m_out && m_acc && bus.mem_rvalid && m_own_d;
    efr = m_out && m_acc && bus.mem_rvalid && !m_own_d && !m_kill && !bus.f_flush;
    check("f_gnt", bus.f_gnt, 32'(ef));
    check("d_gnt", bus.d_gnt, 32'(ed));
    check("f_rvalid", bus.f_rvalid, 32'(efr));
    check("d_rvalid", bus.d_rvalid, 32'(edr));
    check("busy", bus.busy, 32'(m_out));
    check("mem_req", bus.mem_req, 32'(m_out && !m_acc));
    check("rdata", bus.rdata, bus.mem_rdata);
    if (m_out) begin
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_we", 32'(bus.mem_we), 32'(m_we));
      if (m_own_d) check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    s_f_gnt = bus.f_gnt; s_d_gnt = bus.d_gnt; s_f_rv = bus.f_rvalid; s_d_rv = bus.d_rvalid;
    s_mem_req = bus.mem_req; s_busy = bus.busy; s_addr = bus.mem_addr; s_we = bus.mem_we;
    s_rdata = bus.rdata;
    if (log_en && (bus.f_gnt || bus.d_gnt)) begin
      g_order = (g_order << 1) | 32'(bus.f_gnt);
      g_count++;
    end
    if (!bus.f_req || ef) m_streak = 0;
    else if (ed && m_streak < MAX) m_streak++;
    if (!m_out) begin
      if (ed || ef) begin
        m_out = 1; m_acc = 0; m_kill = 0; m_own_d = ed;
        m_addr = ed ? bus.d_addr : bus.f_addr;
        m_we = ed ? bus.d_we : 4'h0;
        m_wdata = bus.d_wdata;
      end
    end else begin
      if (!m_own_d && bus.f_flush) m_kill = 1;
      if (!m_acc) begin
        if (bus.mem_gnt) m_acc = 1;
      end else if (bus.mem_rvalid) begin
        m_out = 0;
      end
    end
    @(negedge clk);
  endtask

  // Legal random drive: requests hold until granted, memory answers only when it may.
  task automatic drive(input int pf, input int pd, input int pg, input int pr, input int pfl);
    if (!(bus.f_req && !s_f_gnt)) begin
      bus.f_req  = ($urandom_range(99) < pf);
      bus.f_addr = $urandom;
    end
    if (!(bus.d_req && !s_d_gnt)) begin
      bus.d_req   = ($urandom_range(99) < pd);
      bus.d_addr  = $urandom;
      bus.d_we    = $urandom_range(1) != 0 ? 4'($urandom) : 4'h0;
      bus.d_wdata = $urandom;
    end
    bus.f_flush    = ($urandom_range(99) < pfl);
    bus.mem_gnt    = m_out && !m_acc && ($urandom_range(99) < pg);
    bus.mem_rvalid = m_out && m_acc && ($urandom_range(99) < pr);
    bus.mem_rdata  = $urandom;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (!m_out && !bus.f_req && !bus.d_req) done = 1;
      else begin
        drive(0, 0, 100, 100, 0);
        cycle();
      end
    end
    check("drain_done", 32'(done), 32'd1);
    clear_inputs();
    cycle();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    log_en = 0;
    g_count = 0;
    g_order = '0;
    @(negedge clk);
    check("rst_f_gnt", bus.f_gnt, 32'd0);
    check("rst_d_gnt", bus.d_gnt, 32'd0);
    check("rst_rvalid", 32'(bus.f_rvalid | bus.d_rvalid), 32'd0);
    check("rst_mem_req", bus.mem_req, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single load
    bus.d_req = 1; bus.d_addr = 32'h100; bus.d_we = 4'h0;
    cycle();
    check("load_gnt", s_d_gnt, 32'd1);
    bus.d_req = 0; bus.mem_gnt = 1;
    cycle();
    check("load_mem_req", s_mem_req, 32'd1);
    check("load_mem_addr", s_addr, 32'h100);
    check("load_mem_we", 32'(s_we), 32'd0);
    bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
    cycle();
    check("load_rvalid", s_d_rv, 32'd1);
    check("load_rdata", s_rdata, 32'hDEADBEEF);
    check("load_f_rvalid", s_f_rv, 32'd0);
    clear_inputs();
    cycle();

    // Store with memory grant delayed three cycles
    bus.d_req = 1; bus.d_addr = 32'h202; bus.d_we = 4'b1100; bus.d_wdata = 32'h12345678;
    cycle();
    check("store_gnt", s_d_gnt, 32'd1);
    bus.d_req = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("store_mem_req", s_mem_req, 32'd1);
      check("store_mem_we", 32'(s_we), 32'hC);
    end
    bus.mem_gnt = 1;
    cycle();
    bus.mem_gnt = 0; bus.mem_rvalid = 1;
    cycle();
    check("store_ack", s_d_rv, 32'd1);
    bus.mem_rvalid = 0;
    cycle();
    check("store_ack_once", s_d_rv, 32'd0);

    // Contention: both always requesting, memory always ready
    log_en = 1;
    for (int i = 0; i < 80 && g_count < 10; i++) begin
      drive(100, 100, 100, 100, 0);
      cycle();
    end
    log_en = 0;
    check("grant_count", g_count, 32'd10);
    check("grant_order", g_order, 32'h21);
    drain();

    // Fetch flushed while waiting for memory
    bus.f_req = 1; bus.f_addr = 32'h40;
    cycle();
    check("flush_f_gnt", s_f_gnt, 32'd1);
    bus.f_req = 0; bus.mem_gnt = 1;
    cycle();
    bus.mem_gnt = 0; bus.f_flush = 1;
    cycle();
    bus.f_flush = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE0001;
    bus.d_req = 1; bus.d_addr = 32'h300; bus.d_we = 4'h0;
    cycle();
    check("flush_no_rvalid", s_f_rv, 32'd0);
    check("flush_d_wait", s_d_gnt, 32'd0);
    bus.mem_rvalid = 0;
    cycle();
    check("flush_next_gnt", s_d_gnt, 32'd1);
    drain();

    // Flush has no effect on a data transaction
    bus.d_req = 1; bus.d_addr = 32'h304; bus.d_we = 4'h0;
    cycle();
    bus.d_req = 0; bus.mem_gnt = 1;
    cycle();
    bus.mem_gnt = 0; bus.f_flush = 1;
    cycle();
    bus.mem_rvalid = 1;
    cycle();
    check("dflush_rvalid", s_d_rv, 32'd1);
    clear_inputs();
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(40, 40, 60, 60, 10);
      cycle();
    end
    drain();

    // Asynchronous reset while in WAIT
    bus.d_req = 1; bus.d_addr = 32'h500; bus.d_we = 4'h0;
    cycle();
    bus.d_req = 0; bus.mem_gnt = 1;
    cycle();
    bus.mem_gnt = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 32'd0);
    check("arst_mem_req", bus.mem_req, 32'd0);
    check("arst_mem_addr", bus.mem_addr, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1;
    cycle();
    check("arst_no_d_rvalid", s_d_rv, 32'd0);
    check("arst_no_f_rvalid", s_f_rv, 32'd0);
    clear_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that lets the instruction-fetch path and the load/store path share one unified memory. It sits between the core (fetch unit and the control unit's byte-enable / data outputs) and the memory port. It serialises accesses with a one-outstanding-transaction FSM, gives data accesses priority with a starvation guard for fetch, and drops responses to flushed fetches.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; the width of `d_we` is `DATA_W/8`.
- `MAX_STREAK`, 4, number of consecutive data grants made while fetch waits before fetch is forced to win once. Legal range is 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request; held stable until `f_gnt`.
- `f_addr`  in  ADDR_W  fetch address.
- `f_flush`  in  1  discard the outstanding fetch response (branch/jump redirect).
- `f_gnt`  out  1  fetch request accepted (1-cycle pulse).
- `f_rvalid`  out  1  fetch data valid on `rdata` (1-cycle pulse).
- `d_req`  in  1  data request; held stable until `d_gnt`.
- `d_addr`  in  ADDR_W  data address.
- `d_we`  in  DATA_W/8  byte write enables; all-zero means read.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted (1-cycle pulse).
- `d_rvalid`  out  1  load data valid, or store acknowledged (1-cycle pulse).
- `rdata`  out  DATA_W  response data shared by both requesters; equals `mem_rdata`.
- `mem_req`  out  1  memory request valid.
- `mem_addr`  out  ADDR_W  memory address (registered).
- `mem_we`  out  DATA_W/8  memory byte enables (registered).
- `mem_wdata`  out  DATA_W  memory write data (registered).
- `mem_gnt`  in  1  memory accepted request this cycle.
- `mem_rvalid`  in  1  memory response valid; only legal in WAIT.
- `mem_rdata`  in  DATA_W  memory response data.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states are IDLE, REQ and WAIT.
- **IDLE:**
  - When any request is pending, select a winner.
  - Assert the winner's `*_gnt` combinationally in the same cycle.
  - Latch address, `we` (forced to 0 for fetch), wdata and `owner`, then go to REQ.
  - With no request pending, stay in IDLE.
- **Arbitration (IDLE only):**
  - Data wins when both request, unless `streak == MAX_STREAK`; in that case fetch wins.
  - `streak` increments on every data grant made while `f_req` = 1, saturating at `MAX_STREAK`.
  - `streak` clears on any fetch grant, and in any cycle where `f_req` = 0.
- **REQ:**
  - `mem_req` = 1, and mem_addr/mem_we/mem_wdata stay stable.
  - On `mem_gnt`, go to WAIT.
  - `mem_rvalid` is ignored in REQ.
- **WAIT:**
  - `mem_req` = 0.
  - On `mem_rvalid`, pulse `d_rvalid` (owner = data) or `f_rvalid` (owner = fetch and `kill` = 0) combinationally in the same cycle, then go to IDLE.
- **Flush:**
  - `f_flush` while owner = fetch and state is REQ or WAIT sets `kill`.
  - The transaction still completes on memory, but `f_rvalid` is suppressed.
  - `kill` clears on return to IDLE.
  - `f_flush` has no effect in IDLE, or when owner = data.
  - `f_flush` in the same cycle as the fetch's `mem_rvalid` suppresses that `f_rvalid`.
- **Data transactions:** never killed. A store with `d_we` ≠ 0 always produces a `d_rvalid` ack.
- **Request rules:**
  - A requester deasserting `req` before `gnt` is a protocol violation, and the bench asserts against it.
  - `gnt` is never asserted outside IDLE.
- **Reset:** asynchronous. State = IDLE; `streak`, `kill`, `owner` = 0; mem_req/mem_addr/mem_we/mem_wdata = 0. Reset mid-transaction abandons it, with no `rvalid` after reset.

## Timing
- Reset values:
  - All gnt/rvalid outputs, `mem_req` and `busy` = 0.
  - `rdata` follows `mem_rdata` (not registered).
- The minimum transaction is 3 cycles:
  - cycle 0: IDLE + gnt;
  - cycle 1: REQ with `mem_gnt`;
  - cycle 2: WAIT with `mem_rvalid`.
- The next grant can occur in the cycle after `rvalid`, so peak throughput is 1 access per 3 cycles.
- `mem_gnt` stall: REQ holds indefinitely and outputs stay unchanged.
- `gnt` → `mem_req` latency is exactly 1 cycle.
- `rvalid` is combinational from `mem_rvalid` (0-cycle pass-through) in WAIT.

## Test plan
- **Single load.** Drive `d_req` with `d_addr`=0x100 and `d_we`=0; memory grants immediately and returns 0xDEADBEEF one cycle later.
  - `d_gnt` pulses at cycle 0; `mem_req` is high at cycle 1 with `mem_addr`=0x100 and `mem_we`=0.
  - `d_rvalid` pulses at cycle 2 with `rdata`=0xDEADBEEF; `f_rvalid` stays 0.
- **Store ack.** Drive `d_we`=4'b1100, `d_wdata`=0x12345678, `d_addr`=0x202 with `mem_gnt` delayed 3 cycles.
  - `mem_req` holds for 3 cycles with `mem_we`=1100.
  - `d_rvalid` pulses once after `mem_rvalid`.
- **Contention and starvation.** Hold `f_req` and `d_req` high continuously with `MAX_STREAK`=4.
  - Grant order is D,D,D,D,F,D,D,D,D,F.
  - `streak` = 0 right after each F grant.
- **Fetch flush.** After `f_gnt`, pulse `f_flush` during WAIT; memory then returns data.
  - No `f_rvalid` is produced.
  - A following `d_req` is granted the cycle after `mem_rvalid`.
- **Flush is ignored for data.** Pulse `f_flush` while a data transaction is in WAIT.
  - `d_rvalid` still pulses.
- **Async reset in WAIT.** Drop `rst_n` mid-cycle while in WAIT.
  - `busy`, `mem_req` and `mem_addr` go to 0 immediately.
  - A later `mem_rvalid` produces no `*_rvalid`.
